// File: rtl/qar_gpio_ctrl.sv
// qar_gpio_ctrl: memory-mapped GPIO controller with input synchroniser,
// atomic set/clear/toggle of outputs and per-pin edge interrupts.
module qar_gpio_ctrl #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DIR_RESET = '0,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_valid,
  input  logic             bus_we,
  input  logic [5:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic             bus_ready,
  output logic [31:0]      bus_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_dir,
  output logic             irq
);
  typedef enum logic {IDLE, RESP} state_t;
  localparam int AW = $clog2(SYNC_STAGES + 2);
  state_t state;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_in, prev_in, rise, fall, wd, clr;
  logic [WIDTH-1:0] irq_en, irq_rise, irq_fall, irq_pend;
  logic [AW-1:0] arm;
  logic armed, accept, wr;
  logic [3:0] word;
  logic [31:0] rd;
  assign accept = state == IDLE && bus_valid;
  assign wr = accept && bus_we;
  assign word = bus_addr[5:2];
  assign wd = bus_wdata[WIDTH-1:0];
  assign sync_in = sync[SYNC_STAGES-1];
  // edges stay masked until the sync chain and prev_in hold real pad values
  assign armed = arm == AW'(SYNC_STAGES + 1);
  assign rise = armed ? sync_in & ~prev_in : '0;
  assign fall = armed ? ~sync_in & prev_in : '0;
  assign clr = (wr && word == 4'h9) ? wd : '0;
  assign bus_ready = state == RESP;
  assign irq = |(irq_pend & irq_en);
  always_comb begin
    rd = '0;
    case (word)
      4'h0: rd[WIDTH-1:0] = gpio_out;
      4'h1: rd[WIDTH-1:0] = gpio_dir;
      4'h2: rd[WIDTH-1:0] = sync_in;
      4'h6: rd[WIDTH-1:0] = irq_en;
      4'h7: rd[WIDTH-1:0] = irq_rise;
      4'h8: rd[WIDTH-1:0] = irq_fall;
      4'h9: rd[WIDTH-1:0] = irq_pend;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus_rdata <= '0;
      gpio_out <= OUT_RESET;
      gpio_dir <= DIR_RESET;
      irq_en <= '0;
      irq_rise <= '0;
      irq_fall <= '0;
      irq_pend <= '0;
      sync <= '0;
      prev_in <= '0;
      arm <= '0;
    end else begin
      state <= accept ? RESP : IDLE;
      sync <= {sync[SYNC_STAGES-2:0], gpio_in};
      prev_in <= sync_in;
      arm <= armed ? arm : arm + 1'b1;
      // set beats clear when both hit the same bit in one cycle
      irq_pend <= (irq_pend & ~clr) | (rise & irq_rise) | (fall & irq_fall);
      if (accept && !bus_we) bus_rdata <= rd;
      if (wr)
        case (word)
          4'h0: gpio_out <= wd;
          4'h1: gpio_dir <= wd;
          4'h3: gpio_out <= gpio_out | wd;
          4'h4: gpio_out <= gpio_out & ~wd;
          4'h5: gpio_out <= gpio_out ^ wd;
          4'h6: irq_en <= wd;
          4'h7: irq_rise <= wd;
          4'h8: irq_fall <= wd;
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_qar_gpio_ctrl.sv
// tb_qar_gpio_ctrl: directed test of qar_gpio_ctrl (WIDTH=8) with a read-data
// scoreboard queue drained by a monitor on each bus_ready pulse.
module tb_qar_gpio_ctrl;
  logic clk = 0, rst_n = 0, bus_valid = 0, bus_we = 0;
  logic [5:0] bus_addr = 0;
  logic [31:0] bus_wdata = 0, bus_rdata;
  logic bus_ready, irq;
  logic [7:0] gpio_in = 8'hFF, gpio_out, gpio_dir;
  int errors = 0, checks = 0;
  typedef struct {logic chk; logic [31:0] exp; string name;} exp_t;
  exp_t q[$];
  logic prev_rdy = 0;

  qar_gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic c, input logic [31:0] e, input string n);
    exp_t x;
    x.chk = c;
    x.exp = e;
    x.name = n;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (bus_ready) begin
      if (prev_rdy) chk("ready_double_pulse", 1, 0);
      if (q.size() == 0) chk("unexpected_ready", 1, 0);
      else begin
        exp_t x;
        x = q.pop_front();
        if (x.chk) chk(x.name, bus_rdata, x.exp);
      end
    end
    prev_rdy <= bus_ready;
  end

  task automatic acc(input logic we, input logic [5:0] a, input logic [31:0] d,
                     input logic [31:0] e, input string name);
    int n;
    push(!we, e, name);
    @(negedge clk);
    bus_valid = 1; bus_we = we; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    n = 1;
    while (!bus_ready && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, n, 1);
    @(negedge clk);
    bus_valid = 0;
    @(posedge clk); #1;
    chk({name, "_ready_drop"}, bus_ready, 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(3);
    chk("rst_out", gpio_out, 0);
    chk("rst_dir", gpio_dir, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ready", bus_ready, 0);
    chk("rst_rdata", bus_rdata, 0);
    @(negedge clk) rst_n = 1;
    cyc(10);
    acc(0, 6'h24, 0, 32'h0, "pend_after_rst");
    acc(0, 6'h08, 0, 32'hFF, "data_in");
    // output register operations
    acc(1, 6'h04, 32'hFF, 0, "w_dir");
    acc(1, 6'h00, 32'h0F, 0, "w_out");
    chk("out_0f", gpio_out, 32'h0F);
    acc(1, 6'h0C, 32'h30, 0, "w_set");
    chk("out_3f", gpio_out, 32'h3F);
    acc(1, 6'h10, 32'h01, 0, "w_clr");
    chk("out_3e", gpio_out, 32'h3E);
    acc(1, 6'h14, 32'h81, 0, "w_tgl");
    chk("out_bf", gpio_out, 32'hBF);
    chk("dir_ff", gpio_dir, 32'hFF);
    acc(0, 6'h00, 0, 32'hBF, "r_out");
    acc(0, 6'h04, 0, 32'hFF, "r_dir");
    // bus_valid held: ack every second cycle
    repeat (3) push(1, 32'hBF, "r_out_held");
    @(negedge clk);
    bus_valid = 1; bus_we = 0; bus_addr = 6'h00;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("held_ready_pattern", bus_ready, (k % 2 == 0) ? 1 : 0);
    end
    bus_valid = 0;
    // rising-edge interrupt latency
    gpio_in = 8'h00;
    cyc(5);
    acc(1, 6'h1C, 32'h01, 0, "w_rise");
    acc(1, 6'h18, 32'h01, 0, "w_en");
    chk("irq_idle", irq, 0);
    @(negedge clk) gpio_in = 8'h01;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("irq_rise_latency", irq, k == 3 ? 1 : 0);
    end
    acc(0, 6'h24, 0, 32'h01, "pend_rise");
    @(negedge clk) gpio_in = 8'h00;
    cyc(5);
    acc(0, 6'h24, 0, 32'h01, "pend_after_fall");
    // write-1-to-clear
    acc(1, 6'h24, 32'h01, 0, "w_pend_clr");
    chk("irq_cleared", irq, 0);
    acc(0, 6'h24, 0, 32'h00, "pend_cleared");
    // clear and rise on the same edge: set wins
    @(negedge clk) gpio_in = 8'h01;
    cyc(5);
    chk("irq_rearmed", irq, 1);
    @(negedge clk) gpio_in = 8'h00;
    cyc(5);
    @(negedge clk) gpio_in = 8'h01;
    @(posedge clk);
    @(posedge clk);
    push(0, 0, "w_pend_clr_race");
    @(negedge clk);
    bus_valid = 1; bus_we = 1; bus_addr = 6'h24; bus_wdata = 32'h01;
    @(posedge clk); #1;
    chk("set_wins_irq", irq, 1);
    @(negedge clk) bus_valid = 0;
    cyc(1);
    acc(0, 6'h24, 0, 32'h01, "pend_set_wins");
    // write-only / unmapped / upper bits
    acc(0, 6'h0C, 0, 32'h0, "r_set_zero");
    acc(0, 6'h30, 0, 32'h0, "r_unmapped");
    acc(1, 6'h00, 32'hFFFFFF5A, 0, "w_out_wide");
    chk("out_5a", gpio_out, 32'h5A);
    acc(0, 6'h00, 0, 32'h5A, "r_out_upper_zero");
    acc(1, 6'h30, 32'hFFFFFFFF, 0, "w_unmapped");
    acc(0, 6'h00, 0, 32'h5A, "r_out_after_unmapped");
    acc(0, 6'h04, 0, 32'hFF, "r_dir_after_unmapped");
    acc(0, 6'h18, 0, 32'h01, "r_en_after_unmapped");
    acc(0, 6'h1C, 0, 32'h01, "r_rise_after_unmapped");
    acc(0, 6'h20, 0, 32'h00, "r_fall_after_unmapped");
    // reset while in RESP
    @(negedge clk);
    bus_valid = 1; bus_we = 0; bus_addr = 6'h00;
    @(posedge clk); #1;
    chk("resp_before_rst", bus_ready, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_ready", bus_ready, 0);
    chk("mid_rst_out", gpio_out, 0);
    chk("mid_rst_dir", gpio_dir, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_rdata", bus_rdata, 0);
    bus_valid = 0;
    @(negedge clk) rst_n = 1;
    cyc(4);
    acc(0, 6'h18, 0, 32'h00, "r_en_post_rst");
    acc(1, 6'h00, 32'h12, 0, "w_out_post_rst");
    acc(0, 6'h00, 0, 32'h12, "r_out_post_rst");
    cyc(3);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
